// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I-subset control FSM: sequences the shared ALU and the unified memory port.
// Optional macro ILLEGAL_TRAP_EN: unsupported decodes park in TRAP instead of retiring as a NOP.
module multicycle_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             mem_w,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_w,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       alu_ctrl,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, JAL, JALR_EX, JALR_PC, ALUWB, TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_AND = 3'b010, ALU_XOR = 3'b011,
                         ALU_SRA = 3'b100, ALU_PASSB = 3'b101;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q, ill_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (instr_done) retired_q <= retired_q + CNT_W'(1);
      if (ill_set)    illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ill_set    = 1'b0;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_w      = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_w      = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_ctrl   = ALU_ADD;
    instr_done = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if ((op == OP_LOAD || op == OP_STORE) && funct3 == 3'b010) state_d = MEMADR;
        else if (op == OP_R && (funct3 == 3'b000 || funct3 == 3'b100 ||
                                funct3 == 3'b101 || funct3 == 3'b111)) state_d = EXECR;
        else if ((op == OP_I && funct3 == 3'b000) || op == OP_LUI) state_d = EXECI;
        else if (op == OP_JAL) state_d = JAL;
        else if (op == OP_JALR && funct3 == 3'b000) state_d = JALR_EX;
        else begin
          ill_set = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          state_d = TRAP;
`else
          // PC already advanced in FETCH, so retiring here makes it a NOP.
          instr_done = 1'b1;
          state_d    = FETCH;
`endif
        end
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
        mem_w      = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        case (funct3)
          3'b111:  alu_ctrl = ALU_AND;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = ALU_SRA;
          default: alu_ctrl = ALU_ADD;
        endcase
        state_d = ALUWB;
      end
      EXECI: begin
        alu_src_b = 2'b01;
        if (op == OP_LUI) alu_ctrl  = ALU_PASSB;
        else              alu_src_a = 2'b10;
        state_d = ALUWB;
      end
      // JALR_PC shares JAL's outputs: PC <= ALUOut (target), ALU computes OldPC+4 for rd.
      JAL, JALR_PC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      JALR_EX: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = JALR_PC;
      end
      ALUWB: begin
        reg_w      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  assign retired = retired_q;
  assign illegal = illegal_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle control words checked against hand-derived vectors.
module tb_multicycle_ctrl_fsm;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [6:0]  op = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, adr_src, mem_w, ir_write, pc_write, reg_w, instr_done, illegal;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_ctrl;
  logic [31:0] retired;

  multicycle_ctrl_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src), .mem_w(mem_w), .ir_write(ir_write),
    .pc_write(pc_write), .reg_w(reg_w), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_ctrl(alu_ctrl), .instr_done(instr_done),
    .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  wire [15:0] obs = {mem_req, adr_src, mem_w, ir_write, pc_write, reg_w,
                     alu_src_a, alu_src_b, result_src, alu_ctrl, instr_done};

  int          checks = 0, failures = 0;
  logic [15:0] exp_w [16];
  bit          rdy_v [16];
  logic [31:0] exp_ret = '0;
  logic        exp_ill = 1'b0;
  logic [15:0] W_FRDY, W_FWAIT, W_DEC, W_MADR, W_MRD, W_MWB, W_MWR, W_MWRW,
               W_WB, W_JEX, W_JPC, W_ADDI, W_LUI, W_ZERO;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] cw(input bit req, adr, mw, irw, pcw, rw,
                                     input bit [1:0] a, b, rs, input bit [2:0] alu, input bit done);
    return {req, adr, mw, irw, pcw, rw, a, b, rs, alu, done};
  endfunction

  function automatic logic [15:0] w_execr(input bit [2:0] alu);
    return cw(0,0,0,0,0,0, 2'd2, 2'd0, 2'd0, alu, 0);
  endfunction

  task automatic setv(input int i, input bit r, input logic [15:0] w);
    rdy_v[i] = r;
    exp_w[i] = w;
  endtask

  // One instruction, n cycles starting in FETCH; retired/illegal model advances from the vectors.
  task automatic run(input string nm, input logic [6:0] o, input logic [2:0] f,
                     input int n, input bit ill);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      op = o; funct3 = f; mem_ready = rdy_v[i];
      #2;
      chk($sformatf("%s.c%0d.ctl", nm, i + 1), 32'(obs), 32'(exp_w[i]));
      chk($sformatf("%s.c%0d.ret", nm, i + 1), retired, exp_ret);
      chk($sformatf("%s.c%0d.ill", nm, i + 1), 32'(illegal), 32'(exp_ill));
      if (exp_w[i][0]) exp_ret++;
      if (ill && i == 1) exp_ill = 1'b1;
    end
  endtask

  task automatic std4(input string nm, input logic [6:0] o, input logic [2:0] f, input logic [15:0] w3);
    setv(0, 1, W_FRDY); setv(1, 1, W_DEC); setv(2, 1, w3); setv(3, 1, W_WB);
    run(nm, o, f, 4, 0);
  endtask

  initial begin
    W_FRDY  = cw(1,0,0,1,1,0, 2'd0, 2'd2, 2'd2, 3'd0, 0);
    W_FWAIT = cw(1,0,0,0,0,0, 2'd0, 2'd2, 2'd2, 3'd0, 0);
    W_DEC   = cw(0,0,0,0,0,0, 2'd1, 2'd1, 2'd0, 3'd0, 0);
    W_MADR  = cw(0,0,0,0,0,0, 2'd2, 2'd1, 2'd0, 3'd0, 0);
    W_MRD   = cw(1,1,0,0,0,0, 2'd0, 2'd0, 2'd0, 3'd0, 0);
    W_MWB   = cw(0,0,0,0,0,1, 2'd0, 2'd0, 2'd1, 3'd0, 1);
    W_MWR   = cw(1,1,1,0,0,0, 2'd0, 2'd0, 2'd0, 3'd0, 1);
    W_MWRW  = cw(1,1,1,0,0,0, 2'd0, 2'd0, 2'd0, 3'd0, 0);
    W_WB    = cw(0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 3'd0, 1);
    W_JEX   = cw(0,0,0,0,0,0, 2'd2, 2'd1, 2'd0, 3'd0, 0);
    W_JPC   = cw(0,0,0,0,1,0, 2'd1, 2'd2, 2'd0, 3'd0, 0);
    W_ADDI  = cw(0,0,0,0,0,0, 2'd2, 2'd1, 2'd0, 3'd0, 0);
    W_LUI   = cw(0,0,0,0,0,0, 2'd0, 2'd1, 2'd0, 3'd5, 0);
    W_ZERO  = '0;

    #12;
    chk("rst.ctl", 32'(obs), 32'(W_ZERO));
    chk("rst.ret", retired, 32'd0);
    chk("rst.ill", 32'(illegal), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1; #2;
    chk("idle.ctl", 32'(obs), 32'(W_ZERO));

    std4("add",  7'b0110011, 3'b000, w_execr(3'd0));
    std4("xor",  7'b0110011, 3'b100, w_execr(3'd3));
    std4("and",  7'b0110011, 3'b111, w_execr(3'd2));
    std4("sra",  7'b0110011, 3'b101, w_execr(3'd4));
    std4("addi", 7'b0010011, 3'b000, W_ADDI);
    std4("lui",  7'b0110111, 3'b011, W_LUI);
    std4("jal",  7'b1101111, 3'b010, W_JPC);

    setv(0, 0, W_FWAIT); setv(1, 0, W_FWAIT); setv(2, 1, W_FRDY); setv(3, 1, W_DEC);
    setv(4, 1, W_MADR);  setv(5, 0, W_MRD);   setv(6, 0, W_MRD);  setv(7, 0, W_MRD);
    setv(8, 1, W_MRD);   setv(9, 1, W_MWB);
    run("lw", 7'b0000011, 3'b010, 10, 0);

    setv(0, 1, W_FRDY); setv(1, 1, W_DEC); setv(2, 1, W_MADR); setv(3, 1, W_MWR);
    run("sw", 7'b0100011, 3'b010, 4, 0);
    setv(0, 1, W_FRDY); setv(1, 1, W_DEC); setv(2, 1, W_MADR);
    setv(3, 0, W_MWRW); setv(4, 0, W_MWRW); setv(5, 1, W_MWR);
    run("swwait", 7'b0100011, 3'b010, 6, 0);

    setv(0, 1, W_FRDY); setv(1, 1, W_DEC); setv(2, 1, W_JEX); setv(3, 1, W_JPC); setv(4, 1, W_WB);
    run("jalr", 7'b1100111, 3'b000, 5, 0);

`ifdef ILLEGAL_TRAP_EN
    setv(0, 1, W_FRDY); setv(1, 1, W_DEC);
    setv(2, 1, W_ZERO); setv(3, 1, W_ZERO); setv(4, 1, W_ZERO);
    run("trap", 7'b1111111, 3'b000, 5, 1);
    @(posedge clk); #1; rst_n = 1'b0; #1; rst_n = 1'b1;
    exp_ret = '0; exp_ill = 1'b0;
`else
    setv(0, 1, W_FRDY); setv(1, 1, W_DEC | 16'h0001);
    run("illop", 7'b1111111, 3'b000, 2, 1);
    std4("postill", 7'b0110011, 3'b000, w_execr(3'd0));
`endif

    setv(0, 1, W_FRDY); setv(1, 1, W_DEC); setv(2, 1, W_MADR); setv(3, 0, W_MRD); setv(4, 0, W_MRD);
    run("lwrst", 7'b0000011, 3'b010, 5, 0);
    @(posedge clk); #1; mem_ready = 1'b0; rst_n = 1'b0; #1;
    chk("midrst.ctl", 32'(obs), 32'(W_ZERO));
    chk("midrst.ret", retired, 32'd0);
    chk("midrst.ill", 32'(illegal), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1; #2;
    chk("midrst.idle", 32'(obs), 32'(W_ZERO));
    exp_ret = '0; exp_ill = 1'b0;
    setv(0, 1, W_FRDY);
    run("midrst.fetch", 7'b0110011, 3'b000, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Multicycle control unit for the RV32I-subset core. It replaces the single-cycle main decoder's per-instruction strobes with a Moore/Mealy state machine that sequences one shared ALU and one unified instruction/data memory port over 4-5 cycles per instruction. Memory accesses use a request/ready handshake. The block also keeps a retired-instruction counter. It sits between the instruction register and the datapath muxes and enables.

## Interface
- `CNT_W`, 32: width of retired-instruction counter
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `op`  in  7  instruction[6:0], from the instruction register
- `funct3`  in  3  instruction[14:12]
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request, held until `mem_ready`
- `adr_src`  out  1  0 = PC, 1 = ALUOut as the memory address
- `mem_w`  out  1  store strobe; valid only while `mem_req`=1
- `ir_write`  out  1  latch the fetched word into IR/OldPC
- `pc_write`  out  1  PC <= Result
- `reg_w`  out  1  register file write
- `alu_src_a`  out  2  00 = PC, 01 = OldPC, 10 = rs1
- `alu_src_b`  out  2  00 = rs2, 01 = imm, 10 = constant 4
- `result_src`  out  2  00 = ALUOut, 01 = Data reg, 10 = ALU result
- `alu_ctrl`  out  3  000 add, 010 and, 011 xor, 100 sra, 101 pass B
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction
- `retired`  out  CNT_W  count of completed instructions
- `illegal`  out  1  sticky; unsupported op/funct3 decoded

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, JAL, JALR_EX, JALR_PC, ALUWB, TRAP.
- Every output defaults to 0 in every state; the items below list only the nonzero values.
- IDLE: no outputs. Always goes to FETCH.
- FETCH: `mem_req`, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, add, `result_src`=10. `ir_write` and `pc_write` are asserted only when `mem_ready`=1. Holds in FETCH while `mem_ready`=0, otherwise goes to DECODE.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, add (ALUOut = OldPC+imm). Next state by `op`/`funct3`:
  - 0000011/010 → MEMADR
  - 0100011/010 → MEMADR
  - 0110011 with funct3 000/100/101/111 → EXECR
  - 0010011/000 → EXECI
  - 0110111 → EXECI
  - 1101111 → JAL
  - 1100111/000 → JALR_EX
  - anything else → illegal handling (see Configuration)
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, add. Loads go to MEMREAD, stores go to MEMWRITE.
- MEMREAD: `mem_req`, `adr_src`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `result_src`=01, `reg_w`, `instr_done`. Goes to FETCH.
- MEMWRITE: `mem_req`, `adr_src`=1, `mem_w`. Holds until `mem_ready`. `instr_done` is asserted in the `mem_ready` cycle. Goes to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00. `alu_ctrl` from funct3: 000→000, 111→010, 100→011, 101→100. Goes to ALUWB.
- EXECI:
  - ADDI: `alu_src_a`=10, `alu_src_b`=01, add.
  - LUI: `alu_src_b`=01, pass B.
  - Goes to ALUWB.
- JAL: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, `pc_write`. Goes to ALUWB.
- JALR_EX: `alu_src_a`=10, `alu_src_b`=01, add. Goes to JALR_PC.
- JALR_PC: same outputs as JAL (PC <= rs1+imm, ALU = OldPC+4). Goes to ALUWB.
- ALUWB: `result_src`=00, `reg_w`, `instr_done`. Goes to FETCH.
- `retired` increments by 1 on every `instr_done` cycle and wraps modulo 2^CNT_W.

## Timing
- All state, `retired` and `illegal` reset asynchronously to IDLE/0/0. All outputs are 0 during reset and in the first cycle after release.
- Latency with zero wait (`mem_ready` high on the first request cycle):
  - R-type, ADDI, LUI, JAL, SW: 4 cycles
  - LW, JALR: 5 cycles
  - Each cycle `mem_ready` stays low adds one cycle in the waiting state.
- The handshake completes in the cycle where `mem_req`=1 and `mem_ready`=1. While waiting, all outputs stay stable.
- `mem_ready` asserted outside a request state is ignored.
- Reset asserted mid-instruction returns the block to IDLE immediately. No write strobe is asserted in the reset cycle.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - Unsupported decode goes to TRAP and sets `illegal`.
  - TRAP asserts no outputs, self-loops until reset, and never pulses `instr_done`.
- `ILLEGAL_TRAP_EN` undefined:
  - Unsupported decode goes straight to FETCH and behaves as a NOP. The PC has already advanced by 4.
  - `illegal` is set (sticky), `instr_done` pulses in DECODE, and `retired` increments.

## Test plan
- ADD (op 0110011, f3 000), `mem_ready` always 1 → states FETCH, DECODE, EXECR, ALUWB; `reg_w`=1 only in cycle 4; `retired` 0→1.
- LW (op 0000011, f3 010), `mem_ready` low 2 cycles in FETCH and 3 cycles in MEMREAD → `instr_done` in cycle 10; `adr_src`=1 only in MEMREAD.
- SW (op 0100011, f3 010) → `mem_w`=1 with `mem_req`=1 in cycle 4 only; `reg_w` never asserted.
- JALR (op 1100111) → `pc_write` in cycles 1 and 4; `reg_w` in cycle 5; `alu_src_a`=10 in cycle 3.
- op 1111111, both macro settings → with `ILLEGAL_TRAP_EN`: TRAP, `illegal`=1, `retired` frozen; without it: `illegal`=1, back in FETCH at cycle 3.
- Drop `rst_n` in the MEMREAD wait → all outputs 0 at once; after release: IDLE, then FETCH; `retired`=0.
